// File: rtl/jesd204b_pkg.sv
// Shared JESD204B transport-layer helpers: frame geometry and the bit
// positions of the fields inside one sample word. Used by both the receive
// and transmit transport layers so the two sides always agree on layout.
package jesd204b_pkg;

    localparam int ERR_COUNT_W = 8;

    // Converters rounded up to a whole number of lanes.
    function automatic int calc_cp(input int converters, input int lanes);
        return ((converters + lanes - 1) / lanes) * lanes;
    endfunction

    // Total frame width in bits across all lanes.
    function automatic int calc_fw(input int samples, input int sample_size,
                                   input int converters, input int lanes);
        return samples * sample_size * calc_cp(converters, lanes);
    endfunction

    // Sample word is {data, ctrl, tail}, MSB first; tail sits at bit 0.
    function automatic int tail_width(input int sample_size, input int resolution,
                                      input int control);
        return sample_size - resolution - control;
    endfunction

    function automatic int ctrl_lsb(input int sample_size, input int resolution,
                                    input int control);
        return tail_width(sample_size, resolution, control);
    endfunction

    function automatic int data_lsb(input int sample_size, input int resolution,
                                    input int control);
        return tail_width(sample_size, resolution, control) + control;
    endfunction

endpackage

// File: rtl/jesd204b_tpl_fifo.sv
// Small register-based FIFO between the deframer and the sample consumer.
// The input-side ready is registered so it never depends on the consumer's
// ready in the same cycle.
module jesd204b_tpl_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             in_ready,
    input  logic             pop,
    output logic             out_valid,
    output logic [WIDTH-1:0] dout
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push   = push && in_ready;
    assign do_pop    = pop && (count != '0);
    assign out_valid = (count != '0);
    assign dout      = mem[rd_ptr];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next = count + CW'(do_push) - CW'(do_pop);
    end

    // Pointers, occupancy and registered ready; ready is low throughout reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count    <= count_next;
            in_ready <= (count_next != CW'(DEPTH));
        end
    end

    // Storage is cleared on reset so the outputs read as zero while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/jesd204b_rx_tpl.sv
// JESD204B receive transport layer: splits a deframed multi-lane frame into
// per-converter data and control fields, checks the tail bits of real
// converters, and buffers unpacked frames in a 2-entry FIFO.
module jesd204b_rx_tpl
    import jesd204b_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int CONVERTERS  = 8,
    parameter int RESOLUTION  = 11,
    parameter int CONTROL     = 2,
    parameter int SAMPLE_SIZE = 16,
    parameter int SAMPLES     = 1
) (
    input  logic                                                    clk,
    input  logic                                                    rst_n,
    input  logic [calc_fw(SAMPLES, SAMPLE_SIZE, CONVERTERS, LANES)-1:0] rx_datain,
    input  logic                                                    rx_valid,
    output logic                                                    rx_ready,
    output logic [SAMPLES*CONVERTERS*RESOLUTION-1:0]                rx_dataout,
    output logic [SAMPLES*CONVERTERS*CONTROL-1:0]                   rx_ctrl,
    output logic                                                    out_valid,
    input  logic                                                    out_ready,
    output logic                                                    tail_err,
    output logic [ERR_COUNT_W-1:0]                                  err_count,
    input  logic                                                    err_clear
);

    localparam int CP       = calc_cp(CONVERTERS, LANES);
    localparam int FW       = SAMPLES * SAMPLE_SIZE * CP;
    localparam int NW       = SAMPLES * CONVERTERS;
    localparam int TAIL_W   = tail_width(SAMPLE_SIZE, RESOLUTION, CONTROL);
    localparam int CTRL_LSB = ctrl_lsb(SAMPLE_SIZE, RESOLUTION, CONTROL);
    localparam int DATA_LSB = data_lsb(SAMPLE_SIZE, RESOLUTION, CONTROL);
    localparam int DATA_W   = NW * RESOLUTION;
    localparam int CTRL_W   = NW * CONTROL;
    localparam int FIFO_W   = DATA_W + CTRL_W + 1;

    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic [NW-1:0]     word_tail_err;
    logic              frame_err;
    logic              push;
    logic              pop;
    logic [FIFO_W-1:0] head;
    logic              head_err_unused;
    logic [FW-1:0]     padding_unused;

    // Padding words beyond the real converters are intentionally never examined.
    assign padding_unused = rx_datain;

    for (genvar j = 0; j < NW; j++) begin : g_word
        logic [SAMPLE_SIZE-1:0] word;
        assign word = rx_datain[j*SAMPLE_SIZE +: SAMPLE_SIZE];
        assign in_data[j*RESOLUTION +: RESOLUTION] = word[DATA_LSB +: RESOLUTION];
        assign in_ctrl[j*CONTROL +: CONTROL]       = word[CTRL_LSB +: CONTROL];
        if (TAIL_W > 0) begin : g_tail
            assign word_tail_err[j] = |word[TAIL_W-1:0];
        end else begin : g_no_tail
            assign word_tail_err[j] = 1'b0;
        end
    end

    assign frame_err = |word_tail_err;
    assign push      = rx_valid && rx_ready;
    assign pop       = out_valid && out_ready;

    jesd204b_tpl_fifo #(
        .WIDTH(FIFO_W),
        .DEPTH(2)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .din      ({frame_err, in_ctrl, in_data}),
        .in_ready (rx_ready),
        .pop      (pop),
        .out_valid(out_valid),
        .dout     (head)
    );

    assign rx_dataout      = head[DATA_W-1:0];
    assign rx_ctrl         = head[DATA_W +: CTRL_W];
    assign head_err_unused = head[FIFO_W-1];

    // Error status follows accepted frames; clear wins over a same-cycle error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tail_err  <= 1'b0;
            err_count <= '0;
        end else if (err_clear) begin
            tail_err  <= 1'b0;
            err_count <= '0;
        end else if (push && frame_err) begin
            tail_err <= 1'b1;
            if (err_count != '1) err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_jesd204b_rx_tpl.sv
// Bench for jesd204b_rx_tpl: directed scenarios plus randomized traffic,
// all checked against a queue-based model of the transport layer.
module tb_jesd204b_rx_tpl;

    localparam int FW  = 128;
    localparam int DW  = 88;
    localparam int CW  = 16;
    localparam int DW2 = 66;
    localparam int CW2 = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [FW-1:0] rx_datain;
    logic          rx_valid, rx_ready;
    logic [DW-1:0] rx_dataout;
    logic [CW-1:0] rx_ctrl;
    logic          out_valid, out_ready, tail_err, err_clear;
    logic [7:0]    err_count;

    logic [FW-1:0]  rx_datain_b;
    logic           rx_valid_b, rx_ready_b;
    logic [DW2-1:0] rx_dataout_b;
    logic [CW2-1:0] rx_ctrl_b;
    logic           out_valid_b, out_ready_b, tail_err_b, err_clear_b;
    logic [7:0]     err_count_b;

    jesd204b_rx_tpl dut (
        .clk(clk), .rst_n(rst_n), .rx_datain(rx_datain), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .rx_dataout(rx_dataout), .rx_ctrl(rx_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .tail_err(tail_err),
        .err_count(err_count), .err_clear(err_clear)
    );

    jesd204b_rx_tpl #(.LANES(4), .CONVERTERS(6)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx_datain(rx_datain_b), .rx_valid(rx_valid_b),
        .rx_ready(rx_ready_b), .rx_dataout(rx_dataout_b), .rx_ctrl(rx_ctrl_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .tail_err(tail_err_b),
        .err_count(err_count_b), .err_clear(err_clear_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic          err;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } frame_t;

    // Reference decode: each 16-bit word is data*32 + ctrl*8 + tail.
    function automatic frame_t decode(input logic [FW-1:0] f);
        frame_t r;
        int unsigned w;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            w = 32'((f >> (16 * j)) & 128'hFFFF);
            r.data = r.data | (DW'(w / 32) << (11 * j));
            r.ctrl = r.ctrl | (CW'((w / 8) % 4) << (2 * j));
            if (w % 8 != 0) r.err = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [FW-1:0] rand_frame(input bit with_tail);
        logic [FW-1:0] f;
        logic [15:0]   w;
        f = '0;
        for (int j = 0; j < 8; j++) begin
            w = 16'($urandom);
            if (!with_tail) w = w & 16'hFFF8;
            f[16*j +: 16] = w;
        end
        return f;
    endfunction

    // Model state: frames in flight, expected ready and error status.
    frame_t q[$];
    bit     m_ready = 1'b0;
    bit     m_terr  = 1'b0;
    int     m_cnt   = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                m_ready = 1'b0;
                m_terr  = 1'b0;
                m_cnt   = 0;
            end else begin
                frame_t f;
                bit     acc;
                f   = decode(rx_datain);
                acc = rx_valid && m_ready;
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (acc) q.push_back(f);
                m_ready = (q.size() < 2);
                if (err_clear) begin
                    m_terr = 1'b0;
                    m_cnt  = 0;
                end else if (acc && f.err) begin
                    m_terr = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                end
            end
        end
    end

    // Compare process on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_out_valid", out_valid, 0);
                chk("rst_rx_ready", rx_ready, 0);
                chk("rst_dataout", rx_dataout, 0);
                chk("rst_ctrl", rx_ctrl, 0);
                chk("rst_tail_err", tail_err, 0);
                chk("rst_err_count", err_count, 0);
            end else begin
                chk("cmp_rx_ready", rx_ready, m_ready);
                chk("cmp_out_valid", out_valid, q.size() != 0);
                if (q.size() != 0) begin
                    chk("cmp_dataout", rx_dataout, q[0].data);
                    chk("cmp_ctrl", rx_ctrl, q[0].ctrl);
                end
                chk("cmp_tail_err", tail_err, m_terr);
                chk("cmp_err_count", err_count, m_cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [10:0]     d36 [8];
    logic [FW-1:0]   f36, f38, fa, fb, fc, f39;
    logic [DW2-1:0]  exp2;
    logic [CW2-1:0]  exp2c;
    frame_t          fr;
    int unsigned     w2;

    initial begin
        rst_n = 1'b1; rx_valid = 0; out_ready = 0; err_clear = 0; rx_datain = '0;
        rx_valid_b = 0; rx_datain_b = '0; out_ready_b = 1; err_clear_b = 0;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_ready_low", rx_ready, 0);
        rst_n = 1'b1;
        chk("ready_before_edge", rx_ready, 0);
        tick();
        chk("ready_rise", rx_ready, 1);

        // Reference frame: conv0 = 11'h67b ... conv7 = 11'h61b.
        d36 = '{11'h67b, 11'h6bb, 11'h73b, 11'h63b, 11'h65b, 11'h69b, 11'h71b, 11'h61b};
        f36 = '0;
        f36[15:0] = 16'hCF60;
        for (int j = 1; j < 8; j++) f36[16*j +: 16] = {d36[j], 5'b00000};
        fr = decode(f36);
        chk("pin_model_data", fr.data,
            {11'h61b, 11'h71b, 11'h69b, 11'h65b, 11'h63b, 11'h73b, 11'h6bb, 11'h67b});
        rx_datain = f36; rx_valid = 1;
        tick();
        rx_valid = 0;
        chk("first_valid", out_valid, 1);
        chk("first_data", rx_dataout,
            {11'h61b, 11'h71b, 11'h69b, 11'h65b, 11'h63b, 11'h73b, 11'h6bb, 11'h67b});
        chk("first_ctrl", rx_ctrl, 0);
        chk("first_tail", tail_err, 0);
        out_ready = 1;
        tick();
        out_ready = 0;
        chk("drained", out_valid, 0);

        // Backpressure: third frame waits until the FIFO drains.
        fa = rand_frame(0); fb = rand_frame(0); fc = rand_frame(0);
        rx_datain = fa; rx_valid = 1;
        tick();
        rx_datain = fb;
        tick();
        chk("full_ready_low", rx_ready, 0);
        rx_datain = fc;
        tick();
        chk("full_still_low", rx_ready, 0);
        fr = decode(fa);
        chk("hold_head_a", rx_dataout, fr.data);
        out_ready = 1;
        tick();
        fr = decode(fb);
        chk("order_b", rx_dataout, fr.data);
        chk("ready_reopen", rx_ready, 1);
        tick();
        rx_valid = 0;
        fr = decode(fc);
        chk("order_c", rx_dataout, fr.data);
        chk("c_valid", out_valid, 1);
        tick();
        chk("bp_drained", out_valid, 0);

        // Tail error counting and saturation.
        f38 = '0;
        f38[47:32] = 16'hCF61;
        fr = decode(f38);
        chk("pin_model_err", fr.err, 1);
        rx_datain = f38; rx_valid = 1;
        tick();
        rx_valid = 0;
        chk("tail_err_set", tail_err, 1);
        chk("err_count_one", err_count, 8'h01);
        rx_valid = 1;
        repeat (299) tick();
        rx_valid = 0;
        chk("err_count_sat", err_count, 8'hFF);
        tick();
        err_clear = 1; rx_valid = 1;
        tick();
        err_clear = 0; rx_valid = 0;
        chk("clear_tail_err", tail_err, 0);
        chk("clear_priority", err_count, 8'h00);
        rx_valid = 1;
        tick();
        rx_valid = 0;
        chk("count_resumes", err_count, 8'h01);
        err_clear = 1;
        tick();
        err_clear = 0;
        chk("cleared_again", err_count, 8'h00);
        tick();

        // Six converters on four lanes: words 6 and 7 are padding.
        f39 = '0; exp2 = '0; exp2c = '0;
        for (int j = 0; j < 6; j++) begin
            w2 = $urandom & 32'hFFF8;
            f39[16*j +: 16] = 16'(w2);
            exp2  = exp2 | (DW2'(w2 / 32) << (11 * j));
            exp2c = exp2c | (CW2'((w2 / 8) % 4) << (2 * j));
        end
        f39[127:96] = 32'hFFFF_FFFF;
        rx_datain_b = f39; rx_valid_b = 1;
        tick();
        rx_valid_b = 0;
        chk("pad_valid", out_valid_b, 1);
        chk("pad_data", rx_dataout_b, exp2);
        chk("pad_ctrl", rx_ctrl_b, exp2c);
        chk("pad_no_tail_err", tail_err_b, 0);
        chk("pad_no_count", err_count_b, 0);
        f39[80] = 1'b1;
        rx_datain_b = f39; rx_valid_b = 1;
        tick();
        rx_valid_b = 0;
        chk("pad_real_tail_err", tail_err_b, 1);
        tick();

        // Reset while two frames are buffered.
        out_ready = 0;
        rx_datain = rand_frame(1); rx_valid = 1;
        tick();
        rx_datain = rand_frame(1);
        tick();
        rx_valid = 0;
        chk("prerst_full", rx_ready, 0);
        chk("prerst_valid", out_valid, 1);
        #1 rst_n = 0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data", rx_dataout, 0);
        chk("midrst_ctrl", rx_ctrl, 0);
        chk("midrst_ready", rx_ready, 0);
        tick();
        rst_n = 1;
        chk("release_ready_low", rx_ready, 0);
        tick();
        chk("release_ready_high", rx_ready, 1);
        chk("release_empty", out_valid, 0);

        // Streaming: one frame per cycle, latency 1.
        out_ready = 1; rx_valid = 1;
        for (int i = 0; i < 20; i++) begin
            fa = rand_frame(0);
            rx_datain = fa;
            tick();
            fr = decode(fa);
            chk("stream_valid", out_valid, 1);
            chk("stream_data", rx_dataout, fr.data);
            chk("stream_ready", rx_ready, 1);
        end
        rx_valid = 0;
        tick();

        // Randomized traffic with occasional clears and one reset pulse.
        for (int i = 0; i < 3000; i++) begin
            rx_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            err_clear = ($urandom % 50) == 0;
            rx_datain = rand_frame(($urandom % 10) < 3);
            if (i == 1500) rst_n = 0;
            if (i == 1503) rst_n = 1;
            tick();
        end
        rx_valid = 0; out_ready = 1; err_clear = 0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jesd204b_rx_tpl.md
JESD204B_RX_TPL -- requirements
Module: jesd204b_rx_tpl

Interface
REQ-001 Parameter LANES, default 4, number of lanes in the link.
REQ-002 Parameter CONVERTERS, default 8, number of converters.
REQ-003 Parameter RESOLUTION, default 11, converter resolution in bits.
REQ-004 Parameter CONTROL, default 2, control bits per sample.
REQ-005 Parameter SAMPLE_SIZE, default 16, bits per sample word (N').
REQ-006 Parameter SAMPLES, default 1, samples per converter per frame.
REQ-007 The module SHALL define the derived constant CP = CONVERTERS rounded up to a multiple of LANES, and FW = SAMPLES*SAMPLE_SIZE*CP.
REQ-008 clk  input  1  single clock; all logic rising-edge.
REQ-009 rst_n  input  1  reset, asynchronous, active-low.
REQ-010 rx_datain  input  FW  deframed lane data; lane k occupies slice [(k+1)*FW/LANES-1 : k*FW/LANES].
REQ-011 rx_valid  input  1  rx_datain holds a frame.
REQ-012 rx_ready  output  1  a frame is accepted on a cycle where rx_valid and rx_ready are both high.
REQ-013 rx_dataout  output  SAMPLES*CONVERTERS*RESOLUTION  recovered samples; converter 0 / sample 0 in the LSBs.
REQ-014 rx_ctrl  output  SAMPLES*CONVERTERS*CONTROL  recovered control bits, same ordering.
REQ-015 out_valid  output  1  rx_dataout/rx_ctrl hold a frame.
REQ-016 out_ready  input  1  consumer accepts the frame when out_valid and out_ready are both high.
REQ-017 tail_err  output  1  sticky; set when any real-converter tail field is nonzero.
REQ-018 err_count  output  8  saturating count of frames that have a tail error.
REQ-019 err_clear  input  1  synchronous clear of tail_err and err_count.

Function
REQ-020 Sample word j (j = 0..SAMPLES*CP-1) SHALL be rx_datain[(j+1)*SAMPLE_SIZE-1 : j*SAMPLE_SIZE], laid out MSB-first as {data[RESOLUTION], ctrl[CONTROL], tail[SAMPLE_SIZE-RESOLUTION-CONTROL]}.
REQ-021 Words j >= SAMPLES*CONVERTERS are padding and SHALL be discarded without a tail check.
REQ-022 The block SHALL buffer accepted frames in a 2-entry FIFO holding unpacked data, ctrl and per-frame error flag.
REQ-023 rx_ready SHALL equal "FIFO not full", taken from registered state only, with no combinational path from out_ready.
REQ-024 Frames SHALL leave the FIFO in acceptance order; out_valid SHALL equal "FIFO not empty".
REQ-025 An accepted frame SHALL appear on the outputs on the cycle after acceptance when the FIFO was empty.
REQ-026 Simultaneous push and pop on a full FIFO SHALL NOT occur, because rx_ready is low when full; simultaneous push and pop at occupancy 1 SHALL keep occupancy at 1.
REQ-027 rx_dataout and rx_ctrl SHALL be stable while out_valid is high and out_ready is low.
REQ-028 tail_err and err_count SHALL update on frame acceptance, not on output; err_count SHALL saturate at 8'hFF.
REQ-029 err_clear SHALL take priority over a same-cycle error increment.
REQ-030 When SAMPLE_SIZE = RESOLUTION+CONTROL there is no tail field, and tail_err SHALL be constant 0.

Reset
REQ-031 While rst_n is low, the FIFO SHALL be empty, out_valid 0, rx_ready 0, tail_err 0, err_count 0, and rx_dataout and rx_ctrl all zeros.
REQ-032 rx_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-033 Reset asserted mid-transfer SHALL discard all buffered frames; no partial frame SHALL be presented afterwards.

Structure
REQ-034 A shared package jesd204b_pkg SHALL hold the CP/FW computation functions and the sample-word field-offset constants, shared with the transmit transport layer.
REQ-035 The FIFO SHALL be a sub-module jesd204b_tpl_fifo, parameterised by width and depth 2.

Verification
REQ-036 Default parameters; frame with samples 11'h61b,11'h71b,11'h69b,11'h65b,11'h63b,11'h73b,11'h6bb,11'h67b (conv0 = 11'h67b), ctrl 0, tail 0, i.e. word0 = 16'hCF60 -> next cycle out_valid=1, rx_dataout equals that concatenation, tail_err=0.
REQ-037 Hold out_ready=0 and push 3 frames -> rx_ready drops after 2 are accepted; raise out_ready -> frames 1 and 2 are output in order, and the third is then accepted.
REQ-038 Word2 = 16'hCF61 (tail 3'b001) -> tail_err=1, err_count=1; 300 such frames -> err_count=8'hFF; err_clear -> both return to 0.
REQ-039 CONVERTERS=6, LANES=4 (CP=8) with nonzero padding words 6 and 7 -> the padding is ignored and tail_err stays 0.
REQ-040 Pulse rst_n low while the FIFO holds 2 frames -> out_valid=0 and outputs are zero immediately; rx_ready=1 one edge after release.
REQ-041 Continuous rx_valid with out_ready=1 -> one frame per cycle, latency 1, no bubbles.
